// File: rtl/dma_line_fetch_if.sv
// Shared RAM bus and cpu park handshake between dma_line_fetch (master) and the cpu/RAM side.
interface dma_line_fetch_if;
    logic        cpu_hold;
    logic        cpu_busy;
    logic        mem_sel;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;

    modport master (
        output cpu_hold,
        output mem_sel,
        output mem_addr,
        input  cpu_busy,
        input  mem_rdata
    );

    modport slave (
        input  cpu_hold,
        input  mem_sel,
        input  mem_addr,
        output cpu_busy,
        output mem_rdata
    );
endinterface

// File: rtl/dma_line_fetch.sv
// Bus-master DMA: parks the cpu, bursts BURST_LEN words from RAM into a show-ahead line FIFO.
// Optional sticky underrun flag when DMA_UNDERRUN_EN is defined.
module dma_line_fetch #(
    parameter int unsigned BURST_LEN  = 40,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned RAM_WAIT   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [15:0]                   base_addr,
    dma_line_fetch_if.master              bus,
    input  logic                          pix_rd,
    output logic [15:0]                   pix_data,
    output logic                          pix_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          done
`ifdef DMA_UNDERRUN_EN
    ,
    output logic                          underrun
`endif
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = AW + 1;
    localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAddr,
        StWait,
        StCapture,
        StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     ptr_q, ptr_d;
    logic [15:0]     addr_q, addr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hold_q, hold_d;
    logic            sel_q, sel_d;
    logic            done_q, done_d;

    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q, level_d;
    logic [15:0]     fifo_mem [FIFO_DEPTH];

    logic            push, pop, in_flight, room;
    logic [LvlW:0]   occupancy;

    // A read issued but not yet pushed still needs a FIFO slot.
    assign in_flight = (state_q == StWait) || (state_q == StCapture);
    assign occupancy = {1'b0, level_q} + {{LvlW{1'b0}}, in_flight};
    assign room      = occupancy < (LvlW + 1)'(FIFO_DEPTH);
    assign push      = (state_q == StCapture);
    assign pop       = pix_rd && (level_q != '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d   = base_addr;
                    cnt_d   = '0;
                    hold_d  = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.cpu_busy) begin
                    sel_d   = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (room) begin
                    addr_d  = ptr_q;
                    state_d = (RAM_WAIT != 0) ? StWait : StCapture;
                end
            end
            StWait: state_d = StCapture;
            StCapture: begin
                ptr_d   = ptr_q + 16'd1;
                cnt_d   = cnt_q + CntW'(1);
                state_d = (cnt_q == CntW'(BURST_LEN - 1)) ? StRelease : StAddr;
            end
            StRelease: begin
                hold_d  = 1'b0;
                sel_d   = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.mem_rdata;
    end

    assign bus.cpu_hold = hold_q;
    assign bus.mem_sel  = sel_q;
    assign bus.mem_addr = addr_q;
    assign done         = done_q;
    assign fifo_level   = level_q;
    assign pix_valid    = (level_q != '0);
    // Storage is not reset, so the head is forced to zero while empty.
    assign pix_data     = pix_valid ? fifo_mem[rd_ptr_q] : 16'h0000;

`ifdef DMA_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            underrun_q <= 1'b0;
        end else if (pix_rd && !pix_valid) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_dma_line_fetch.sv
// Scoreboard bench for dma_line_fetch: default instance (40/64/wait 1) plus a 32-deep, zero-wait one.
module tb_dma_line_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, start1 = 1'b0;
    logic        pix_rd = 1'b0, pix_rd1 = 1'b0;
    logic [15:0] base_addr = '0, base1 = '0;
    logic [15:0] pix_data, pix_data1;
    logic        pix_valid, pix_valid1;
    logic [6:0]  fifo_level;
    logic [5:0]  fifo_level1;
    logic        done, done1;
`ifdef DMA_UNDERRUN_EN
    logic        underrun, underrun1;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          proto_err = 0;
    logic [15:0] sb[$];
    logic [15:0] sb1[$];
    logic [1:0]  hd, hd1;

    dma_line_fetch_if bus ();
    dma_line_fetch_if bus1 ();

    dma_line_fetch dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .bus(bus),
        .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
        .fifo_level(fifo_level), .done(done)
`ifdef DMA_UNDERRUN_EN
        , .underrun(underrun)
`endif
    );

    dma_line_fetch #(.BURST_LEN(40), .FIFO_DEPTH(32), .RAM_WAIT(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .base_addr(base1), .bus(bus1),
        .pix_rd(pix_rd1), .pix_data(pix_data1), .pix_valid(pix_valid1),
        .fifo_level(fifo_level1), .done(done1)
`ifdef DMA_UNDERRUN_EN
        , .underrun(underrun1)
`endif
    );

    always #5 clk = ~clk;

    // cpu parks two cycles after hold and unparks two cycles after hold drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            hd  <= '0;
            hd1 <= '0;
        end else begin
            hd  <= {hd[0], bus.cpu_hold};
            hd1 <= {hd1[0], bus1.cpu_hold};
        end
    end
    assign bus.cpu_busy   = hd[1];
    assign bus1.cpu_busy  = hd1[1];
    // RAM model: word at address a holds a - 0x0100.
    assign bus.mem_rdata  = bus.mem_addr - 16'h0100;
    assign bus1.mem_rdata = bus1.mem_addr - 16'h0100;

    always @(negedge clk) begin
        if (!reset && bus.mem_sel && !bus.cpu_busy) proto_err++;
        if (!reset && bus1.mem_sel && !bus1.cpu_busy) proto_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; start1 = 1'b0; pix_rd = 1'b0; pix_rd1 = 1'b0;
        sb.delete(); sb1.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", bus.cpu_hold); end
        n_checks++; if (bus.mem_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", bus.mem_sel); end
        n_checks++; if (bus.mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
        n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_checks++; if (pix_data !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data: got %h want 0", pix_data); end
        n_checks++; if (fifo_level1 !== 6'd0) begin n_fail++; $display("FAIL reset_level1: got %0d want 0", fifo_level1); end
    endtask

    task automatic test_single_burst();
        int ndone = 0, first = -1, last = 0, prev;
        apply_reset();
        base_addr = 16'h0100; start = 1'b1;
        for (int i = 0; i < 40; i++) sb.push_back(16'(i));
        @(negedge clk); start = 1'b0;
        n_checks++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL start_hold_latency: got %b want 1", bus.cpu_hold); end
        prev = int'(fifo_level);
        for (int c = 0; c < 400; c++) begin
            if (done) ndone++;
            if (int'(fifo_level) != prev) begin
                if (first < 0) first = c;
                last = c; prev = int'(fifo_level);
            end
            @(negedge clk);
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", ndone); end
        n_checks++; if (fifo_level !== 7'd40) begin n_fail++; $display("FAIL single_level: got %0d want 40", fifo_level); end
        n_checks++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL single_hold_after: got %b want 0", bus.cpu_hold); end
        n_checks++; if (bus.mem_sel !== 1'b0) begin n_fail++; $display("FAIL single_sel_after: got %b want 0", bus.mem_sel); end
        n_checks++; if (last - first != 117) begin n_fail++; $display("FAIL single_throughput: got %0d cycles want 117", last - first); end
        pix_rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] exp_w = sb.pop_front();
            n_checks++; if (pix_data !== exp_w) begin n_fail++; $display("FAIL single_word[%0d]: got %h want %h", i, pix_data, exp_w); end
            @(negedge clk);
        end
        pix_rd = 1'b0;
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained_valid: got %b want 0", pix_valid); end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] seen[$];
        logic [15:0] exp_a[4];
        logic [15:0] prev;
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        apply_reset();
        base_addr = 16'hFFFE; start = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(exp_a[i] - 16'h0100);
        @(negedge clk); start = 1'b0;
        prev = bus.mem_addr;
        for (int c = 0; c < 100 && seen.size() < 4; c++) begin
            if (bus.mem_sel && bus.mem_addr != prev) begin
                seen.push_back(bus.mem_addr); prev = bus.mem_addr;
            end
            @(negedge clk);
        end
        n_checks++; if (seen.size() != 4) begin n_fail++; $display("FAIL wrap_addr_count: got %0d want 4", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            n_checks++; if (seen[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, seen[i], exp_a[i]); end
        end
        for (int c = 0; c < 50 && fifo_level < 7'd4; c++) @(negedge clk);
        pix_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_w = sb.pop_front();
            n_checks++; if (pix_data !== exp_w) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", i, pix_data, exp_w); end
            @(negedge clk);
        end
        pix_rd = 1'b0;
    endtask

    task automatic test_concurrent_pop();
        int ndone = 0, maxl = 0, extra = 0;
        apply_reset();
        base_addr = 16'h0200; start = 1'b1;
        for (int i = 0; i < 40; i++) sb.push_back(16'h0100 + 16'(i));
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (done) ndone++;
            if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
            if (pix_valid) begin
                if (sb.size() == 0) extra++;
                else begin
                    logic [15:0] exp_w = sb.pop_front();
                    n_checks++; if (pix_data !== exp_w) begin n_fail++; $display("FAIL pop_word: got %h want %h", pix_data, exp_w); end
                end
                pix_rd = 1'b1;
            end else pix_rd = 1'b0;
            @(negedge clk);
            if (ndone > 0 && sb.size() == 0 && c > 200) break;
        end
        pix_rd = 1'b0;
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL pop_missing: got %0d left want 0", sb.size()); end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL pop_extra: got %0d extra want 0", extra); end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL pop_done_count: got %0d want 1", ndone); end
        n_checks++; if (maxl > 1) begin n_fail++; $display("FAIL pop_max_level: got %0d want <=1", maxl); end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        apply_reset();
        base_addr = 16'h0100; start = 1'b1;
        for (int i = 0; i < 40; i++) sb.push_back(16'(i));
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c == 20) begin start = 1'b1; base_addr = 16'h3000; end
            else start = 1'b0;
            if (done) ndone++;
            @(negedge clk);
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        n_checks++; if (fifo_level !== 7'd40) begin n_fail++; $display("FAIL ignore_level: got %0d want 40", fifo_level); end
        pix_rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] exp_w = sb.pop_front();
            n_checks++; if (pix_data !== exp_w) begin n_fail++; $display("FAIL ignore_word[%0d]: got %h want %h", i, pix_data, exp_w); end
            @(negedge clk);
        end
        pix_rd = 1'b0;
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        bit hit = 1'b0;
        apply_reset();
        base_addr = 16'h0100; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (fifo_level == 7'd10) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach10: level %0d want 10", fifo_level); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL abort_hold: got %b want 0", bus.cpu_hold); end
        n_checks++; if (bus.mem_sel !== 1'b0) begin n_fail++; $display("FAIL abort_sel: got %b want 0", bus.mem_sel); end
        n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL abort_level: got %0d want 0", fifo_level); end
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", pix_valid); end
        reset = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", ndone); end
        n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL abort_idle_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_backpressure();
        int ndone = 0, first = -1, last = 0, prev;
        apply_reset();
        base1 = 16'h0100; start1 = 1'b1;
        for (int i = 0; i < 40; i++) sb1.push_back(16'(i));
        @(negedge clk); start1 = 1'b0;
        prev = int'(fifo_level1);
        for (int c = 0; c < 300; c++) begin
            if (done1) ndone++;
            if (int'(fifo_level1) != prev) begin
                if (first < 0) first = c;
                last = c; prev = int'(fifo_level1);
            end
            @(negedge clk);
        end
        n_checks++; if (fifo_level1 !== 6'd32) begin n_fail++; $display("FAIL bp_stall_level: got %0d want 32", fifo_level1); end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL bp_early_done: got %0d want 0", ndone); end
        n_checks++; if (bus1.mem_sel !== 1'b1 || bus1.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL bp_bus_kept: sel %b hold %b want 1 1", bus1.mem_sel, bus1.cpu_hold); end
        n_checks++; if (bus1.mem_addr !== 16'h011F) begin n_fail++; $display("FAIL bp_last_addr: got %h want 011f", bus1.mem_addr); end
        n_checks++; if (last - first != 62) begin n_fail++; $display("FAIL bp_throughput: got %0d cycles want 62", last - first); end
        pix_rd1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp_w = sb1.pop_front();
            n_checks++; if (pix_data1 !== exp_w) begin n_fail++; $display("FAIL bp_pop[%0d]: got %h want %h", i, pix_data1, exp_w); end
            @(negedge clk);
        end
        pix_rd1 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done1) ndone++;
            @(negedge clk);
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", ndone); end
        n_checks++; if (fifo_level1 !== 6'd32) begin n_fail++; $display("FAIL bp_final_level: got %0d want 32", fifo_level1); end
        n_checks++; if (bus1.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL bp_hold_after: got %b want 0", bus1.cpu_hold); end
        pix_rd1 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [15:0] exp_w = sb1.pop_front();
            n_checks++; if (pix_data1 !== exp_w) begin n_fail++; $display("FAIL bp_drain[%0d]: got %h want %h", i, pix_data1, exp_w); end
            @(negedge clk);
        end
        pix_rd1 = 1'b0;
    endtask

`ifdef DMA_UNDERRUN_EN
    task automatic test_underrun();
        apply_reset();
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_reset: got %b want 0", underrun); end
        pix_rd = 1'b1;
        @(negedge clk); pix_rd = 1'b0;
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set: got %b want 1", underrun); end
        @(negedge clk);
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_sticky: got %b want 1", underrun); end
        base_addr = 16'h0100; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear: got %b want 0", underrun); end
        repeat (200) @(negedge clk);
    endtask
`endif

    task automatic test_protocol();
        n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL busy_drop_while_sel: got %0d events want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_addr_wrap();
        test_concurrent_pop();
        test_start_ignored();
        test_reset_abort();
        test_backpressure();
`ifdef DMA_UNDERRUN_EN
        test_underrun();
`endif
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
